// File: rtl/cg_pkg.sv
// Shared types for the clock-gate enable controller: FSM states, the
// registered output bundle and its per-state decode.
package cg_pkg;

  localparam int WAKE_W = 4;

  typedef enum logic [1:0] {
    CG_WAKE,
    CG_ON,
    CG_DRAIN,
    CG_OFF
  } cg_state_e;

  typedef struct packed {
    logic clk_en;
    logic sleep_req;
    logic ready;
    logic clk_gated;
  } cg_out_t;

  // Output values for each state. Used on the next state, so that every
  // output comes straight from a flop.
  function automatic cg_out_t cg_decode(input cg_state_e s);
    cg_out_t o;
    o = '{clk_en: 1'b1, sleep_req: 1'b0, ready: 1'b0, clk_gated: 1'b0};
    case (s)
      CG_WAKE:  o = '{clk_en: 1'b1, sleep_req: 1'b0, ready: 1'b0, clk_gated: 1'b0};
      CG_ON:    o = '{clk_en: 1'b1, sleep_req: 1'b0, ready: 1'b1, clk_gated: 1'b0};
      CG_DRAIN: o = '{clk_en: 1'b1, sleep_req: 1'b1, ready: 1'b1, clk_gated: 1'b0};
      CG_OFF:   o = '{clk_en: 1'b0, sleep_req: 1'b1, ready: 1'b0, clk_gated: 1'b1};
      default:  o = '{clk_en: 1'b1, sleep_req: 1'b0, ready: 1'b0, clk_gated: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/cg_if.sv
// Activity, configuration and handshake signals between the gated block
// and its clock-gate enable controller.
interface cg_if #(
  parameter int CNT_W = 8
);
  logic             wake_req;
  logic             busy;
  logic             force_on;
  logic [CNT_W-1:0] idle_thresh;
  logic             sleep_ack;
  logic             clk_en;
  logic             sleep_req;
  logic             ready;
  logic             clk_gated;

  // Block / software side: drives activity and handshake, observes status.
  modport master (
    output wake_req, busy, force_on, idle_thresh, sleep_ack,
    input  clk_en, sleep_req, ready, clk_gated
  );

  // Controller side.
  modport slave (
    input  wake_req, busy, force_on, idle_thresh, sleep_ack,
    output clk_en, sleep_req, ready, clk_gated
  );
endinterface

// File: rtl/cg_idle_cnt.sv
// Saturating idle-cycle counter. at_thresh flags that the current idle
// cycle completes a run of thresh idle cycles (or more, when the threshold
// was lowered below the count already reached). thresh of 0 never hits.
module cg_idle_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] thresh,
  output logic             at_thresh
);

  logic [CNT_W-1:0] cnt;

  // Count idle cycles; clear wins, hold at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt >= thresh-1 rewritten as cnt+1 >= thresh, widened to avoid wrap.
  assign at_thresh = (thresh != '0) &&
                     (({1'b0, cnt} + (CNT_W+1)'(1)) >= {1'b0, thresh});

endmodule

// File: rtl/cg_ctrl.sv
// Enable-side controller for the latch-based clock gate. Gates the block
// clock after a programmable idle period via a sleep_req/sleep_ack
// handshake, and reopens it with a fixed settle period before ready.
//
// state    | meaning
// ---------+---------------------------------------------------------
// CG_WAKE  | clock running, settling for WAKE_CYCLES; ready low
// CG_ON    | clock running and ready; counting idle cycles
// CG_DRAIN | sleep_req raised, waiting for the block to quiesce
// CG_OFF   | clock gated; waiting for wake_req or force_on
module cg_ctrl
  import cg_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int WAKE_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  cg_if.slave bus
);

  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  cg_state_e         state;
  cg_state_e         state_nxt;
  logic [WAKE_W-1:0] wake_cnt;
  logic              act;
  logic              wake;
  logic              at_thresh;
  cg_out_t           out_q;
  cg_out_t           out_nxt;

  assign act  = bus.busy | bus.wake_req | bus.force_on;
  assign wake = bus.wake_req | bus.force_on;

  cg_idle_cnt #(
    .CNT_W (CNT_W)
  ) u_idle_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       ((state != CG_ON) | act),
    .inc       ((state == CG_ON) & ~act),
    .thresh    (bus.idle_thresh),
    .at_thresh (at_thresh)
  );

  // Next-state logic; outputs are decoded from the next state and
  // registered, so nothing from the inputs reaches the pins combinationally.
  always_comb begin
    state_nxt = state;
    case (state)
      CG_WAKE:  if (wake_cnt == WAKE_LAST) state_nxt = CG_ON;
      CG_ON:    if (!act && at_thresh) state_nxt = CG_DRAIN;
      CG_DRAIN: begin
        if (wake)               state_nxt = CG_ON;
        else if (bus.sleep_ack) state_nxt = CG_OFF;
      end
      CG_OFF:   if (wake) state_nxt = CG_WAKE;
      default:  state_nxt = CG_WAKE;
    endcase
    out_nxt = cg_decode(state_nxt);
  end

  // State, settle counter and output registers; reset reopens the clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CG_WAKE;
      wake_cnt <= '0;
      out_q    <= cg_decode(CG_WAKE);
    end else begin
      state    <= state_nxt;
      wake_cnt <= ((state == CG_WAKE) && (state_nxt == CG_WAKE)) ?
                  wake_cnt + 1'b1 : '0;
      out_q    <= out_nxt;
    end
  end

  assign bus.clk_en    = out_q.clk_en;
  assign bus.sleep_req = out_q.sleep_req;
  assign bus.ready     = out_q.ready;
  assign bus.clk_gated = out_q.clk_gated;

endmodule
